// File: rtl/bw_io_bscan_drv_pkg.sv
// bw_io_bscan_drv_pkg: shared AC burst FSM encoding and segment defaults
package bw_io_bscan_drv_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BURST = 2'b01, DONE = 2'b10} ac_state_t;
  localparam int NPAD_DEF      = 4;
  localparam int AC_PULSES_DEF = 8;
  localparam int CNT_W_DEF     = 8;
endpackage

// File: rtl/bw_io_bscan_drv_if.sv
// bw_io_bscan_drv_if: scan control, core and pad signals of the boundary-scan drive segment
interface bw_io_bscan_drv_if #(parameter int NPAD = 4);
  logic            scan_in;
  logic            scan_out;
  logic            capture_dr;
  logic            shift_dr;
  logic            update_dr;
  logic            extest;
  logic            ac_mode;
  logic            ac_start;
  logic [NPAD-1:0] core_data;
  logic [NPAD-1:0] core_oe;
  logic [NPAD-1:0] pad_data;
  logic [NPAD-1:0] pad_oe;
  logic            ac_busy;
  logic            ac_done;
  modport master (
    output scan_in, capture_dr, shift_dr, update_dr, extest, ac_mode, ac_start, core_data, core_oe,
    input  scan_out, pad_data, pad_oe, ac_busy, ac_done
  );
  modport slave (
    input  scan_in, capture_dr, shift_dr, update_dr, extest, ac_mode, ac_start, core_data, core_oe,
    output scan_out, pad_data, pad_oe, ac_busy, ac_done
  );
endinterface

// File: rtl/bw_io_bscan_drv_cell.sv
// bw_io_bscan_drv_cell: one boundary-scan shift flop plus its update flop
module bw_io_bscan_drv_cell (
  input  logic clk,
  input  logic rst_l,
  input  logic i_cap_val,
  input  logic i_si,
  input  logic i_capture,
  input  logic i_shift,
  input  logic i_update,
  output logic o_sh,
  output logic o_upd
);
  logic r_sh;
  logic r_upd;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sh  <= 1'b0;
      r_upd <= 1'b0;
    end else begin
      r_sh  <= i_capture ? i_cap_val : i_shift ? i_si : r_sh;
      r_upd <= i_update ? r_sh : r_upd;
    end
  end
  assign o_sh  = r_sh;
  assign o_upd = r_upd;
endmodule

// File: rtl/bw_io_bscan_drv.sv
// bw_io_bscan_drv: boundary-scan drive segment with EXTEST pad mux and AC toggle burst
module bw_io_bscan_drv
  import bw_io_bscan_drv_pkg::*;
#(
  parameter int NPAD      = NPAD_DEF,
  parameter int AC_PULSES = AC_PULSES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic               clk,
  input logic               rst_l,
  bw_io_bscan_drv_if.slave  bus
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(AC_PULSES - 1);
  logic [2*NPAD-1:0] w_cap, w_si, w_sh, w_upd;
  logic [NPAD-1:0]   w_upd_data, w_upd_oe;
  ac_state_t         r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
  logic              r_tgl, w_tgl_nx;
  logic              w_armed;
  // even chain positions hold oe, odd positions hold data, oe cell 0 sits next to scan_in
  for (genvar i = 0; i < NPAD; i++) begin : g_pad
    assign w_cap[2*i]   = bus.core_oe[i];
    assign w_cap[2*i+1] = bus.core_data[i];
    assign w_upd_oe[i]   = w_upd[2*i];
    assign w_upd_data[i] = w_upd[2*i+1];
  end
  assign w_si = {w_sh[2*NPAD-2:0], bus.scan_in};
  for (genvar k = 0; k < 2*NPAD; k++) begin : g_cell
    bw_io_bscan_drv_cell u_cell (
      .clk       (clk),
      .rst_l     (rst_l),
      .i_cap_val (w_cap[k]),
      .i_si      (w_si[k]),
      .i_capture (bus.capture_dr),
      .i_shift   (bus.shift_dr),
      .i_update  (bus.update_dr),
      .o_sh      (w_sh[k]),
      .o_upd     (w_upd[k])
    );
  end
  assign bus.scan_out = w_sh[2*NPAD-1];
  assign bus.pad_oe   = bus.extest ? w_upd_oe : bus.core_oe;
  assign bus.pad_data = bus.extest ? w_upd_data ^ {NPAD{r_tgl}} : bus.core_data;
  assign bus.ac_busy  = r_state == BURST;
  assign bus.ac_done  = r_state == DONE;
  assign w_armed      = bus.extest & bus.ac_mode;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_tgl   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_tgl   <= w_tgl_nx;
    end
  end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_tgl_nx   = r_tgl;
    case (r_state)
      IDLE: if (bus.ac_start && w_armed) begin
        w_state_nx = BURST;
        w_cnt_nx   = LOAD;
        w_tgl_nx   = 1'b1;
      end
      BURST: if (!w_armed) begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
        w_tgl_nx   = 1'b0;
      end else if (r_cnt == '0) begin
        w_state_nx = DONE;
        w_tgl_nx   = 1'b0;
      end else begin
        w_cnt_nx   = r_cnt - CNT_W'(1);
        w_tgl_nx   = ~r_tgl;
      end
      default: w_state_nx = IDLE;
    endcase
  end
endmodule
